// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: two master request/ack ports plus the shared bridge port
//   m0_*/m1_* : req, addr, byteen (0 = read), wdata in; ack pulse, rdata out
//   bus_*     : addr, byteen, wdata out to the bridge; rdata back from it
//   busy, grant_id : arbiter status
interface bus_arbiter_if;
  logic m0_req, m1_req, m0_ack, m1_ack;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0] m0_byteen, m1_byteen;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0] bus_byteen;
  logic busy, grant_id;
  modport slave (
    input m0_req, m0_addr, m0_byteen, m0_wdata, m1_req, m1_addr, m1_byteen, m1_wdata, bus_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata, bus_addr, bus_byteen, bus_wdata, busy, grant_id
  );
  modport master (
    output m0_req, m0_addr, m0_byteen, m0_wdata, m1_req, m1_addr, m1_byteen, m1_wdata, bus_rdata,
    input m0_ack, m0_rdata, m1_ack, m1_rdata, bus_addr, bus_byteen, bus_wdata, busy, grant_id
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master arbiter onto one bridge port with WAIT extra bus cycles
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bi    : bus_arbiter_if.slave carrying both master ports, the bridge port, busy and grant_id
module bus_arbiter #(
  parameter int WAIT = 0
) (
  input logic clk,
  input logic reset,
  bus_arbiter_if.slave bi
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [3:0] LAST = 4'(WAIT);
  state_t state, state_n;
  logic last_served, pick, grant, bus_end, gid;
  logic [31:0] addr_q, wdata_q, rdata0, rdata1;
  logic [3:0] byteen_q, wcnt;
  // with both requesting, the master not served last wins
  assign pick = (bi.m0_req & bi.m1_req) ? ~last_served : bi.m1_req;
  always_comb begin
    grant = state == IDLE && (bi.m0_req || bi.m1_req);
    bus_end = state == BUS && wcnt == LAST;
    state_n = grant ? BUS : bus_end ? RESP : state == RESP ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      last_served <= 1'b1;
      gid <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      byteen_q <= '0;
      wcnt <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        gid <= pick;
        last_served <= pick;
        addr_q <= pick ? bi.m1_addr : bi.m0_addr;
        wdata_q <= pick ? bi.m1_wdata : bi.m0_wdata;
        byteen_q <= pick ? bi.m1_byteen : bi.m0_byteen;
        wcnt <= '0;
      end else if (state == BUS) wcnt <= wcnt + 4'd1;
      if (bus_end && !gid) rdata0 <= bi.bus_rdata;
      if (bus_end && gid) rdata1 <= bi.bus_rdata;
    end
  assign bi.busy = state != IDLE;
  assign bi.grant_id = gid;
  assign bi.bus_addr = state == BUS ? addr_q : '0;
  assign bi.bus_wdata = state == BUS ? wdata_q : '0;
  // strobe byte enables only in the first bus cycle so a write lands once
  assign bi.bus_byteen = (state == BUS && wcnt == 4'd0) ? byteen_q : '0;
  assign bi.m0_ack = state == RESP && !gid;
  assign bi.m1_ack = state == RESP && gid;
  assign bi.m0_rdata = rdata0;
  assign bi.m1_rdata = rdata1;
endmodule
